mux_scan_reg: RTL

Parametrised N-channel, WIDTH-bit registered multiplexer; successor to the fixed 8:1 combinational mux. It adds a registered output with a valid/ready handshake and an auto-scan mode that steps through channels round-robin with a programmable dwell. It sits between a bank of sampled sources and a single downstream consumer, such as a display or serial stage, that reads one channel at a time.

---
 rtl/mux_scan_reg.sv | 110 +++++++++++
 1 files changed

// File: rtl/mux_scan_reg.sv
// mux_scan_reg: N-channel registered multiplexer with valid/ready output
// and a round-robin auto-scan mode with programmable dwell.
// Optional feature macro: MUX_SCAN_MASK_EN (scan visits only channels whose
// mask bit is set); when undefined the mask port is ignored.
module mux_scan_reg #(
   parameter int WIDTH = 1,
   parameter int CH    = 8,
   parameter int SEL_W = $clog2(CH),
   parameter int DWELL = 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  mode,
   input  logic [SEL_W-1:0]      s,
   input  logic [CH*WIDTH-1:0]   in,
   input  logic [CH-1:0]         mask,
   output logic [WIDTH-1:0]      out,
   output logic [SEL_W-1:0]      out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   localparam logic [15:0] DW_LAST = 16'(DWELL - 1);

   logic [CH-1:0][WIDTH-1:0] in_arr;
   logic [SEL_W-1:0]         ptr, ptr_nxt, ptr_first, sel;
   logic [15:0]              cnt;
   logic                     mode_q;
   logic                     scan_ok, free, cap;
   logic [WIDTH-1:0]         sel_data;

   assign in_arr = in;

`ifdef MUX_SCAN_MASK_EN
   // Next enabled channel after ptr (circular) and lowest enabled channel.
   // The descending loop leaves the lowest qualifying index in each result;
   // with no enabled channel above ptr the search wraps to the lowest one.
   logic [SEL_W-1:0] hi_ch;
   logic             hi_found;
   always_comb begin
      ptr_first = '0;
      hi_ch     = '0;
      hi_found  = 1'b0;
      for (int k = CH - 1; k >= 0; k--) begin
         if (mask[k]) ptr_first = SEL_W'(k);
         if (mask[k] && (SEL_W'(k) > ptr)) begin
            hi_ch    = SEL_W'(k);
            hi_found = 1'b1;
         end
      end
      ptr_nxt = hi_found ? hi_ch : ptr_first;
   end
   // An all-zero mask stalls the scan at the capture point.
   assign scan_ok = |mask;
`else
   // Plain round-robin over all channels.
   always_comb begin
      ptr_first = '0;
      ptr_nxt   = (ptr == SEL_W'(CH - 1)) ? '0 : ptr + SEL_W'(1);
   end
   assign scan_ok = 1'b1;
   logic unused_mask;
   assign unused_mask = ^mask;
`endif

   assign sel = mode ? ptr : s;

   // Channel mux; out-of-range selects produce zero.
   always_comb begin
      sel_data = '0;
      for (int k = 0; k < CH; k++)
         if (sel == SEL_W'(k)) sel_data = in_arr[k];
   end

   // The scan capture is suppressed on the 0->1 mode edge, where ptr/cnt reload.
   assign free = !out_valid || out_ready;
   assign cap  = free && (mode ? (mode_q && (cnt == DW_LAST) && scan_ok) : 1'b1);

   // Output register, handshake, scan pointer and dwell counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         out       <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         ptr       <= '0;
         cnt       <= '0;
         mode_q    <= mode;
      end else begin
         mode_q <= mode;
         if (cap) begin
            out       <= sel_data;
            out_ch    <= sel;
            out_valid <= 1'b1;
         end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         if (mode && !mode_q) begin
            ptr <= ptr_first;
            cnt <= '0;
         end else if (mode) begin
            if (cnt < DW_LAST) cnt <= cnt + 16'd1;
            else if (cap) begin
               ptr <= ptr_nxt;
               cnt <= '0;
            end
         end
      end
   end

endmodule
